// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives a one-cycle synchronous instruction ROM and buffers
// fetched words in a 2-entry FIFO toward decode, handling redirects and faults.
module fetch_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                ROM_WORDS = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [31:0]       i_rom_data,
    output logic              o_inst_valid,
    output logic [31:0]       o_inst_out,
    output logic [ADDR_W-1:0] o_inst_pc,
    input  logic              i_inst_ready,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_fetch_fault
);
    localparam logic [0:0]        S_RUN    = 1'b0;
    localparam logic [0:0]        S_FAULT  = 1'b1;
    localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(4 * ROM_WORDS);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_pc, r_inflight_pc, r_pc0, r_pc1;
    logic              r_inflight;
    logic [1:0]        r_occ;
    logic [31:0]       r_data0, r_data1;

    logic              w_run, w_redir, w_misalign, w_pop, w_push, w_room;
    logic              w_in_range, w_issue, w_oor;
    logic [2:0]        w_pending;
    logic [1:0]        w_tail;

    assign w_run      = r_state == S_RUN;
    // redirects are ignored once faulted, so they neither flush nor squash
    assign w_redir    = w_run & i_redirect_valid;
    assign w_misalign = w_redir & (|i_redirect_pc[1:0]);
    assign w_pop      = o_inst_valid & i_inst_ready;
    assign w_push     = r_inflight & ~w_redir;
    assign w_pending  = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_room     = w_pending < 3'd2;
    assign w_in_range = r_pc < PC_LIMIT;
    assign w_issue    = w_run & ~w_redir & w_room & w_in_range;
    assign w_oor      = w_run & ~w_redir & w_room & ~w_in_range;
    assign w_tail     = r_occ - {1'b0, w_pop};

    assign o_rom_addr    = r_pc;
    assign o_inst_valid  = r_occ != 2'd0;
    assign o_inst_out    = r_data0;
    assign o_inst_pc     = r_pc0;
    assign o_fetch_fault = r_state == S_FAULT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_occ         <= 2'd0;
            r_data0       <= '0;
            r_data1       <= '0;
            r_pc0         <= '0;
            r_pc1         <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + ADDR_W'(4);
            end else if (w_redir && !w_misalign) begin
                r_pc <= i_redirect_pc;
            end
            if (w_misalign || w_oor)
                r_state <= S_FAULT;
            if (w_redir) begin
                r_occ <= 2'd0;
            end else begin
                r_occ <= w_tail + {1'b0, w_push};
                if (w_pop && r_occ == 2'd2) begin
                    r_data0 <= r_data1;
                    r_pc0   <= r_pc1;
                end
                if (w_push && w_tail == 2'd0) begin
                    r_data0 <= i_rom_data;
                    r_pc0   <= r_inflight_pc;
                end
                if (w_push && w_tail == 2'd1) begin
                    r_data1 <= i_rom_data;
                    r_pc1   <= r_inflight_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer against a behavioural ROM.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_addr, inst_out, inst_pc, redirect_pc;
    logic        inst_valid, inst_ready, redirect_valid, fetch_fault;
    logic [31:0] rom_q = '0;
    logic [31:0] rom [0:18];
    int          n_chk = 0;
    int          n_fail = 0;

    fetch_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_rom_addr       (rom_addr),
        .i_rom_data       (rom_q),
        .o_inst_valid     (inst_valid),
        .o_inst_out       (inst_out),
        .o_inst_pc        (inst_pc),
        .i_inst_ready     (inst_ready),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= (rom_addr < 32'd76) ? rom[rom_addr[6:2]] : 32'h0;

    // the FIFO must never be pushed while already full
    always @(negedge clk)
        if (rst_n) assert (!(dut.w_push && dut.w_tail == 2'd2));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_run();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] word);
        check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        check({tag, "_pc"}, inst_pc, pc);
        check({tag, "_word"}, inst_out, word);
    endtask

    initial begin
        for (int i = 0; i < 19; i++) rom[i] = 32'hA5A5_0000 | i;
        rom[0]  = 32'h00450693;
        rom[1]  = 32'h00100713;
        rom[2]  = 32'h00b76463;
        rom[3]  = 32'h00008067;
        rom[7]  = 32'hffc62883;
        rom[8]  = 32'h01185a63;
        rom[16] = 32'h00170713;
        rom[17] = 32'h00468693;
        rom[18] = 32'hfc1ff06f;
        rst_n = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_out", inst_out, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_addr", rom_addr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step();
        check("lat_e1_valid", {31'b0, inst_valid}, 32'd0);
        step(); check_head("seq0", 32'h0, 32'h00450693);
        step(); check_head("seq4", 32'h4, 32'h00100713);
        step(); check_head("seq8", 32'h8, 32'h00b76463);
        step(); check_head("seqc", 32'hc, 32'h00008067);
        check("seq_fault", {31'b0, fetch_fault}, 32'd0);

        reset_run();
        step(); step();
        check_head("bp0", 32'h0, 32'h00450693);
        inst_ready = 1'b0;
        step(); check("bp_addr_e3", rom_addr, 32'h8);
        step(); check("bp_addr_e4", rom_addr, 32'h8);
        step(); check_head("bp_hold", 32'h0, 32'h00450693);
        check("bp_addr_e5", rom_addr, 32'h8);
        inst_ready = 1'b1;
        step(); check_head("bp4", 32'h4, 32'h00100713);
        step(); check_head("bp8", 32'h8, 32'h00b76463);
        step(); check_head("bpc", 32'hc, 32'h00008067);

        reset_run();
        step(); step(); step(); step();
        check_head("rd_pre", 32'h8, 32'h00b76463);
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c;
        step();
        redirect_valid = 1'b0;
        check("rd_flush", {31'b0, inst_valid}, 32'd0);
        check("rd_addr", rom_addr, 32'h1c);
        step(); check("rd_gap", {31'b0, inst_valid}, 32'd0);
        step(); check_head("rd1c", 32'h1c, 32'hffc62883);
        step(); check_head("rd20", 32'h20, 32'h01185a63);

        redirect_valid = 1'b1;
        redirect_pc = 32'h1e;
        step();
        redirect_valid = 1'b0;
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_valid", {31'b0, inst_valid}, 32'd0);
        check("mis_addr", rom_addr, 32'h28);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("mis_ign_addr", rom_addr, 32'h28);
        check("mis_ign_fault", {31'b0, fetch_fault}, 32'd1);
        step(); check("mis_ign_valid", {31'b0, inst_valid}, 32'd0);

        reset_run();
        check("end_rst_fault", {31'b0, fetch_fault}, 32'd0);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("end_flush", {31'b0, inst_valid}, 32'd0);
        check("end_addr", rom_addr, 32'h40);
        step(); check("end_gap", {31'b0, inst_valid}, 32'd0);
        step(); check_head("end40", 32'h40, 32'h00170713);
        step(); check_head("end44", 32'h44, 32'h00468693);
        check("end_nofault", {31'b0, fetch_fault}, 32'd0);
        step(); check_head("end48", 32'h48, 32'hfc1ff06f);
        check("end_fault", {31'b0, fetch_fault}, 32'd1);
        step(); check("end_drain", {31'b0, inst_valid}, 32'd0);
        check("end_addr_hold", rom_addr, 32'h4c);
        step(); check("end_no4c", {31'b0, inst_valid}, 32'd0);

        reset_run();
        inst_ready = 1'b0;
        step(); step(); step();
        check_head("mr_full", 32'h0, 32'h00450693);
        check("mr_addr", rom_addr, 32'h8);
        #3 rst_n = 1'b0;
        #1;
        check("mr_valid", {31'b0, inst_valid}, 32'd0);
        check("mr_addr0", rom_addr, 32'h0);
        check("mr_pc0", inst_pc, 32'h0);
        check("mr_out0", inst_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        inst_ready = 1'b1;
        step(); check("mr_e1", {31'b0, inst_valid}, 32'd0);
        step(); check_head("mr0", 32'h0, 32'h00450693);
        step(); check_head("mr4", 32'h4, 32'h00100713);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the synchronous instruction ROM.
- The ROM has one-cycle registered read: it takes a 32-bit byte address and returns a 32-bit word.
- The block owns the program counter and issues one ROM read per cycle. It tracks the in-flight read, captures returned words into a 2-entry buffer, and presents them to decode with a valid/ready handshake.
- It handles redirects from branch/jump resolution and faults on misaligned or out-of-range fetch addresses.

Parameters:
- ADDR_W, 32, width of PC and ROM address.
- RESET_PC, 32'h0, first fetch address after reset.
- ROM_WORDS, 19, number of populated ROM words; legal fetch addresses are 0 .. 4*ROM_WORDS-4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_addr  out  ADDR_W  address to ROM; ROM samples it at posedge.
- rom_data  in  32  ROM output; holds the word for the address sampled at the previous edge.
- inst_valid  out  1  buffer head is valid.
- inst_out  out  32  instruction word at buffer head.
- inst_pc  out  ADDR_W  byte address of inst_out.
- inst_ready  in  1  decode accepts head; pop = inst_valid & inst_ready.
- redirect_valid  in  1  single-cycle redirect request.
- redirect_pc  in  ADDR_W  redirect target.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Reset (async assert, sync use after deassert):
  - pc=RESET_PC; rom_addr=RESET_PC; inflight=0; buffer empty.
  - inst_valid=0; inst_out=0; inst_pc=0; fetch_fault=0; state=RUN.
- Clock and reset: clk is the single clock; reset is asynchronous and active-low (rst_n).
- rom_addr = pc register (registered, no combinational path from inputs).
- Issue:
  - Condition: state==RUN, no redirect this cycle, pc < 4*ROM_WORDS, and (occ + inflight - pop) < 2.
  - On issue at edge E: inflight<=1, inflight_pc<=pc, pc<=pc+4 (ADDR_W wrap, unsigned).
  - No issue: pc holds, inflight<=0. The ROM re-reading the held address is harmless; its data is not captured.
- Capture: if inflight==1 and not squashed, rom_data and inflight_pc are written to the buffer tail at the next edge. Capture happens only in the cycle directly after issue.
- Buffer:
  - 2-entry FIFO, registered outputs, no bypass.
  - Simultaneous push+pop allowed at any occupancy.
  - Overflow is impossible by the issue rule; the bench asserts it.
- Latency:
  - First edge after reset release issues RESET_PC.
  - inst_valid rises after the second edge.
  - Steady state with inst_ready=1: one instruction per cycle, no bubbles.
- Redirect (redirect_valid=1 in cycle C):
  - At the edge ending C: buffer flushed and the in-flight read squashed. A pop in C completes; its consumer keeps that instruction.
  - If redirect_pc[1:0]!=0: state<=FAULT, fetch_fault<=1, no issue.
  - Otherwise pc<=redirect_pc; issue resumes the next cycle.
  - First redirected instruction is valid 2 edges after the redirect edge.
- Out-of-range: in RUN with pc >= 4*ROM_WORDS and issue otherwise allowed: state<=FAULT, fetch_fault<=1.
  - Buffered and in-flight legal instructions still capture and drain normally.
- FAULT state:
  - No issue; redirect_valid ignored; rom_addr holds.
  - Left only by reset.
- Reset mid-operation: all state returns to reset values immediately on rst_n low. Buffered and in-flight words are discarded.
- States: RUN, FAULT. RUN->FAULT on misaligned redirect or out-of-range issue. FAULT->RUN only via reset.

Test Plan:
- Reset, inst_ready=1: outputs appear one per cycle in order (pc, word):
  - (0, 00450693), (4, 00100713), (8, 00b76463), (0xc, 00008067).
  - inst_valid first high after the second edge; fetch_fault stays 0.
- Backpressure: inst_ready=0 for 3 cycles after the first valid, then 1.
  - Buffer holds pc 0 and 4; rom_addr stalls at 8.
  - Output order resumes 0, 4, 8, 0xc with no loss or duplicate.
- Redirect to 0x1c while pc 0x8/0xc are buffered or in flight:
  - Those are dropped.
  - Next valid is (0x1c, ffc62883), then (0x20, 01185a63), 2 edges after the redirect.
- Misaligned redirect to 0x1e:
  - fetch_fault=1 next cycle; inst_valid=0 after the flush.
  - rom_addr frozen; a later redirect to 0x0 is ignored.
- Sequential run off the end from redirect 0x40 with inst_ready=1:
  - Outputs 00170713 (0x40), 00468693 (0x44), fc1ff06f (0x48).
  - Then fetch_fault=1; no fetch of 0x4c is issued.
- Assert rst_n=0 mid-stream with 2 buffered entries:
  - inst_valid=0 and rom_addr=0 immediately.
  - After release, the stream restarts at pc 0.
